// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the channel FSM state
// types used by both the memory responder and the traffic generator.
// No ports; import with "import axi4_lite_pkg::*;".
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    e_axi_okay   = 2'b00,
    e_axi_slverr = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  // Response code for an access that did or did not decode into the RAM.
  function automatic axi_resp_e resp_for(input logic hit);
    return hit ? e_axi_okay : e_axi_slverr;
  endfunction

endpackage

// File: rtl/axi4_lite_mem_ram.sv
// Word-organised RAM behind the AXI4-Lite responder.
// Ports:
//   clk_i    - clock for the write port
//   we_i     - commit strobe; bytes with wstrb_i set are written
//   waddr_i  - write word index
//   wdata_i  - write data
//   wstrb_i  - byte enables
//   raddr_i  - read word index (combinational read)
//   rdata_o  - read data; the parent registers it
// Contents are deliberately not reset so data survives a bus reset.
module axi4_lite_mem_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_ELS    = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(MEM_ELS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_ELS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // A read sampled on the same edge as a write sees the old word.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4_lite_mem_responder.sv
// AXI4-Lite subordinate backed by an on-chip byte-masked RAM, with
// programmable write/read response latency. One outstanding write and one
// outstanding read, handled by two fully independent channel FSMs.
// Ports:
//   clk_i, reset_n_i           - clock, asynchronous active-low reset
//   awaddr_i/awprot_i/awvalid_i/awready_o - write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o     - write data channel
//   bresp_o/bvalid_o/bready_i             - write response channel
//   araddr_i/arprot_i/arvalid_i/arready_o - read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i     - read data channel
// Accesses at or above MEM_ELS*STRB_WIDTH get SLVERR; writes there are
// dropped and reads return zero. DATA_WIDTH must be 32 or 64 and MEM_ELS a
// power of two.
module axi4_lite_mem_responder
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_ELS    = 1024,
  parameter int WR_LAT     = 0,
  parameter int RD_LAT     = 0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [2:0]            awprot_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [2:0]            arprot_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
);

  localparam int OFFSET = $clog2(STRB_WIDTH);
  localparam int IDX_W  = $clog2(MEM_ELS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_ELS * STRB_WIDTH);
  localparam int WCNT_W = (WR_LAT > 0) ? $clog2(WR_LAT + 1) : 1;
  localparam int RCNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < MEM_BYTES;
  endfunction

  // Protection bits carry no meaning for this memory.
  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  // Write channel
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [WCNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_hs, w_hs, b_hs;
  logic                  wr_commit;
  logic                  ram_we;

  // Read channel
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RCNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  ar_hs, r_hs;
  logic                  rd_capture;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    aw_hs      = awready_q & awvalid_i;
    w_hs       = wready_q & wvalid_i;
    b_hs       = bvalid_q & bready_i;
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_cnt_d   = wr_cnt_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    // Bypass the holding registers so a zero-latency commit can use the
    // beat being accepted on this very edge.
    awaddr_d   = aw_hs ? awaddr_i : awaddr_q;
    wdata_d    = w_hs ? wdata_i : wdata_q;
    wstrb_d    = w_hs ? wstrb_i : wstrb_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (aw_held_d && w_held_d) begin
          if (WR_LAT == 0) begin
            wr_state_d = W_RESP;
            wr_commit  = 1'b1;
          end else begin
            wr_state_d = W_WAIT;
            wr_cnt_d   = WCNT_W'(WR_LAT);
          end
        end
      end
      W_WAIT: begin
        wr_cnt_d = wr_cnt_q - WCNT_W'(1);
        if (wr_cnt_q == WCNT_W'(1)) begin
          wr_state_d = W_RESP;
          wr_commit  = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_commit) bresp_d = resp_for(in_range(awaddr_d));
    bvalid_d  = (wr_state_d == W_RESP);
    awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
  end

  assign ram_we = wr_commit && in_range(awaddr_d);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  always_comb begin
    ar_hs      = arready_q & arvalid_i;
    r_hs       = rvalid_q & rready_i;
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_capture = 1'b0;
    araddr_d   = ar_hs ? araddr_i : araddr_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (RD_LAT == 0) begin
            rd_state_d = R_RESP;
            rd_capture = 1'b1;
          end else begin
            rd_state_d = R_WAIT;
            rd_cnt_d   = RCNT_W'(RD_LAT);
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - RCNT_W'(1);
        if (rd_cnt_q == RCNT_W'(1)) begin
          rd_state_d = R_RESP;
          rd_capture = 1'b1;
        end
      end
      R_RESP: begin
        if (r_hs) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_capture) begin
      rdata_d = in_range(araddr_d) ? ram_rdata : '0;
      rresp_d = resp_for(in_range(araddr_d));
    end
    rvalid_d  = (rd_state_d == R_RESP);
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    araddr_q <= araddr_d;
  end

  axi4_lite_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_ELS    (MEM_ELS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (awaddr_d[OFFSET +: IDX_W]),
    .wdata_i (wdata_d),
    .wstrb_i (wstrb_d),
    .raddr_i (araddr_d[OFFSET +: IDX_W]),
    .rdata_o (ram_rdata)
  );

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rresp_o   = rresp_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// Self-checking bench for axi4_lite_mem_responder (64-bit data, 1024 words,
// WR_LAT = 2, RD_LAT = 3). Directed vectors from a table, hand-written
// sequences for decoupled AW/W, backpressure and reset, then random traffic
// checked against a word-array memory model.
module tb_axi4_lite_mem_responder;

  localparam int WR_LAT_TB = 2;
  localparam int RD_LAT_TB = 3;

  logic        clk;
  logic        reset_n;
  logic [27:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready_o;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready;
  logic [27:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready;

  int checks   = 0;
  int failures = 0;

  axi4_lite_mem_responder #(
    .ADDR_WIDTH (28),
    .DATA_WIDTH (64),
    .MEM_ELS    (1024),
    .WR_LAT     (WR_LAT_TB),
    .RD_LAT     (RD_LAT_TB)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .awaddr_i  (awaddr),
    .awprot_i  (awprot),
    .awvalid_i (awvalid),
    .awready_o (awready_o),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .wvalid_i  (wvalid),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready),
    .araddr_i  (araddr),
    .arprot_i  (arprot),
    .arvalid_i (arvalid),
    .arready_o (arready_o),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1);
  end

  // Reference memory: one entry per RAM word, plus a flag saying whether the
  // whole word has a defined value yet.
  logic [63:0] model [1024];
  bit          known [1024];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [27:0] a, input logic [63:0] d, input logic [7:0] s);
    int idx;
    logic [63:0] w;
    if (a >= 28'h2000) return;
    idx = int'(a[12:3]);
    w = model[idx];
    for (int b = 0; b < 8; b++) begin
      if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    end
    model[idx] = w;
    if (s == 8'hFF) known[idx] = 1'b1;
  endfunction

  // Full write transaction. AW and W are offered after independent delays;
  // the B handshake is delayed by b_dly cycles.
  task automatic do_write(input logic [27:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc, k;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (aw_done) check("awready_low_after_aw", 64'(awready_o), 64'd0);
      if (w_done)  check("wready_low_after_w", 64'(wready_o), 64'd0);
      aw_hs = awvalid && awready_o;
      w_hs  = wvalid && wready_o;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("write_handshakes_done", 64'(aw_done && w_done), 64'd1);
    k = 1;
    while (!bvalid_o && k < 50) begin
      check("awready_low_wait_b", 64'(awready_o), 64'd0);
      @(posedge clk); #1;
      k++;
    end
    check("bvalid_latency", 64'(k), 64'(WR_LAT_TB + 1));
    resp = bresp_o;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); #1;
      check("bvalid_held", 64'(bvalid_o), 64'd1);
      check("bresp_stable", 64'(bresp_o), 64'(resp));
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop_after_b", 64'(bvalid_o), 64'd0);
    check("readies_back_after_b", 64'({awready_o, wready_o}), 64'd3);
  endtask

  // Full read transaction; rready is withheld for r_dly cycles once rvalid rises.
  task automatic do_read(input logic [27:0] a, input int ar_dly, input int r_dly,
                         output logic [63:0] d, output logic [1:0] resp);
    bit done, hs;
    int cyc, k;
    done   = 1'b0;
    cyc    = 0;
    araddr = a;
    while (!done && cyc < 50) begin
      arvalid = (cyc >= ar_dly);
      hs = arvalid && arready_o;
      @(posedge clk); #1;
      done = hs;
      cyc++;
    end
    arvalid = 1'b0;
    check("read_handshake_done", 64'(done), 64'd1);
    k = 1;
    while (!rvalid_o && k < 50) begin
      check("arready_low_wait_r", 64'(arready_o), 64'd0);
      @(posedge clk); #1;
      k++;
    end
    check("rvalid_latency", 64'(k), 64'(RD_LAT_TB + 1));
    d    = rdata_o;
    resp = rresp_o;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); #1;
      check("rvalid_held", 64'(rvalid_o), 64'd1);
      check("rdata_stable", rdata_o, d);
      check("rresp_stable", 64'(rresp_o), 64'(resp));
      check("arready_low_backpressure", 64'(arready_o), 64'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop_after_r", 64'(rvalid_o), 64'd0);
    check("arready_back_after_r", 64'(arready_o), 64'd1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [27:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [1:0]  resp;
    logic [63:0] rd;
    logic [27:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    bit          oor;
    int          idx;

    vecs[0]  = '{1'b1, 28'h0000040, 64'h0123456789ABCDEF, 8'hFF, 2'b00, 64'h0};
    vecs[1]  = '{1'b0, 28'h0000040, 64'h0,                8'h00, 2'b00, 64'h0123456789ABCDEF};
    vecs[2]  = '{1'b1, 28'h0000080, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, 64'h0};
    vecs[3]  = '{1'b1, 28'h0000080, 64'h0,                8'h0F, 2'b00, 64'h0};
    vecs[4]  = '{1'b0, 28'h0000080, 64'h0,                8'h00, 2'b00, 64'hFFFFFFFF00000000};
    vecs[5]  = '{1'b1, 28'h0000000, 64'hAAAA5555AAAA5555, 8'hFF, 2'b00, 64'h0};
    vecs[6]  = '{1'b1, 28'h0002000, 64'h1234123412341234, 8'hFF, 2'b10, 64'h0};
    vecs[7]  = '{1'b0, 28'h0000000, 64'h0,                8'h00, 2'b00, 64'hAAAA5555AAAA5555};
    vecs[8]  = '{1'b0, 28'h0002000, 64'h0,                8'h00, 2'b10, 64'h0};
    vecs[9]  = '{1'b1, 28'h0000084, 64'h1111111111111111, 8'h00, 2'b00, 64'h0};
    vecs[10] = '{1'b0, 28'h0000087, 64'h0,                8'h00, 2'b00, 64'hFFFFFFFF00000000};
    vecs[11] = '{1'b1, 28'h0001FF8, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'b00, 64'h0};
    vecs[12] = '{1'b0, 28'h0001FFF, 64'h0,                8'h00, 2'b00, 64'hDEADBEEFCAFEF00D};
    vecs[13] = '{1'b0, 28'hFFFFFF8, 64'h0,                8'h00, 2'b10, 64'h0};

    reset_n = 1'b0;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_awready", 64'(awready_o), 64'd0);
    check("reset_wready", 64'(wready_o), 64'd0);
    check("reset_arready", 64'(arready_o), 64'd0);
    check("reset_bvalid", 64'(bvalid_o), 64'd0);
    check("reset_bresp", 64'(bresp_o), 64'd0);
    check("reset_rvalid", 64'(rvalid_o), 64'd0);
    check("reset_rresp", 64'(rresp_o), 64'd0);
    check("reset_rdata", rdata_o, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("readies_low_before_first_edge", 64'({awready_o, wready_o, arready_o}), 64'd0);
    @(posedge clk); #1;
    check("readies_up_after_reset", 64'({awready_o, wready_o, arready_o}), 64'd7);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp);
        check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 0, 0, rd, resp);
        check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vecs[i].exp_resp));
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
      end
    end

    // W arrives three cycles after AW; bvalid latency is measured from W
    do_write(28'h0000100, 64'h0A0B0C0D01020304, 8'hFF, 0, 3, 0, resp);
    check("decoupled_bresp", 64'(resp), 64'd0);
    // W first, AW later, plus a stalled B channel
    do_write(28'h0000108, 64'h5566778899AABBCC, 8'hFF, 4, 0, 3, resp);
    check("w_first_bresp", 64'(resp), 64'd0);

    // Read with rready held low for five cycles
    do_read(28'h0000100, 0, 5, rd, resp);
    check("backpressure_rdata", rd, 64'h0A0B0C0D01020304);
    check("backpressure_rresp", 64'(resp), 64'd0);
    do_read(28'h0000108, 2, 0, rd, resp);
    check("w_first_rdata", rd, 64'h5566778899AABBCC);

    // Reset while the read channel is waiting out its latency
    araddr  = 28'h0000080;
    arvalid = 1'b1;
    check("arready_before_reset_read", 64'(arready_o), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    check("rvalid_low_in_wait", 64'(rvalid_o), 64'd0);
    check("arready_low_in_wait", 64'(arready_o), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_rvalid", 64'(rvalid_o), 64'd0);
    check("mid_reset_arready", 64'(arready_o), 64'd0);
    check("mid_reset_wr_readies", 64'({awready_o, wready_o}), 64'd0);
    @(posedge clk); #1;
    check("reset_held_rvalid", 64'(rvalid_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("arready_low_at_release", 64'(arready_o), 64'd0);
    @(posedge clk); #1;
    check("arready_up_after_release", 64'(arready_o), 64'd1);
    check("wr_readies_up_after_release", 64'({awready_o, wready_o}), 64'd3);
    check("no_stale_rvalid", 64'(rvalid_o), 64'd0);
    do_read(28'h0000040, 0, 0, rd, resp);
    check("retained_after_reset", rd, 64'h0123456789ABCDEF);
    do_read(28'h0000080, 0, 0, rd, resp);
    check("retained_masked_word", rd, 64'hFFFFFFFF00000000);

    // Random traffic over a 16-word pool plus occasional out-of-range accesses
    for (int i = 0; i < 16; i++) begin
      a = 28'((100 + i) * 8);
      d = {$urandom, $urandom};
      model_write(a, d, 8'hFF);
      do_write(a, d, 8'hFF, 0, 0, 0, resp);
      check("rand_init_bresp", 64'(resp), 64'd0);
    end
    for (int n = 0; n < 60; n++) begin
      oor = ($urandom_range(0, 7) == 0);
      if (oor) a = 28'h2000 + 28'($urandom_range(0, 32'h0FFFDFFF));
      else     a = 28'((100 + $urandom_range(0, 15)) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom_range(0, 255));
        model_write(a, d, s);
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
        check("rand_bresp", 64'(resp), oor ? 64'd2 : 64'd0);
      end else begin
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), rd, resp);
        check("rand_rresp", 64'(resp), oor ? 64'd2 : 64'd0);
        if (oor) begin
          check("rand_rdata_oor", rd, 64'd0);
        end else begin
          idx = int'(a[12:3]);
          if (known[idx]) check("rand_rdata", rd, model[idx]);
        end
      end
    end

    // Word 0 must not have been touched by any out-of-range write
    do_read(28'h0000000, 0, 0, rd, resp);
    check("word0_unchanged", rd, 64'hAAAA5555AAAA5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
